// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths, reset/bubble encodings
// and the fetch FSM state type.
package cpu_pkg;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 16;

    localparam logic [PC_W-1:0]    RESET_PC  = 16'h0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: bubble has priority over load; otherwise holds.
module if_id_latch
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               bubble,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [PC_W-1:0]    load_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic               valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            valid <= 1'b0;
        end else if (bubble) begin
            // A bubble keeps the old pc; only instr/valid mark it as empty.
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            instr <= load_instr;
            pc    <= load_pc;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, single-outstanding imem requests, stall
// buffer and IF/ID latch. Define FETCH_PERF_CNT_EN to add the stall_cnt output.
module fetch_stage
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_write,
    input  logic               IF_ID_Write,
    input  logic               flush,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    fetch_state_t       state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_inc;
    logic [INSTR_W-1:0] hold_reg;
    logic               discard;
    logic               accept;
    logic               latch_load;
    logic               latch_bubble;
    logic [INSTR_W-1:0] latch_instr_d;

    assign accept = pc_write & IF_ID_Write;
    assign pc_inc = pc + 1'b1;

    always_comb begin
        imem_req      = 1'b0;
        imem_addr     = pc;
        latch_load    = 1'b0;
        latch_bubble  = 1'b0;
        latch_instr_d = imem_rdata;

        if (!rst && !flush) begin
            unique case (state)
                IDLE: imem_req = 1'b1;
                WAIT: begin
                    if (imem_valid && !discard && accept) begin
                        imem_req  = 1'b1;
                        imem_addr = pc_inc;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        imem_req  = 1'b1;
                        imem_addr = pc_inc;
                    end
                end
                default: imem_req = 1'b0;
            endcase
        end

        // With no instruction on hand, a consuming decode stage gets a bubble.
        if (flush) begin
            latch_bubble = 1'b1;
        end else begin
            unique case (state)
                IDLE: latch_bubble = IF_ID_Write;
                WAIT: begin
                    if (imem_valid && !discard) latch_load = accept;
                    else                        latch_bubble = IF_ID_Write;
                end
                HOLD: begin
                    latch_load    = accept;
                    latch_instr_d = hold_reg;
                end
                default: latch_bubble = IF_ID_Write;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            hold_reg <= NOP_INSTR;
            discard  <= 1'b0;
        end else if (flush) begin
            pc <= branch_target;
            if (state == WAIT && !imem_valid) begin
                discard <= 1'b1;
                state   <= WAIT;
            end else begin
                discard <= 1'b0;
                state   <= IDLE;
            end
        end else begin
            unique case (state)
                IDLE: state <= WAIT;
                WAIT: begin
                    if (imem_valid) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= IDLE;
                        end else if (accept) begin
                            pc <= pc_inc;
                        end else begin
                            hold_reg <= imem_rdata;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (accept) begin
                        pc    <= pc_inc;
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((state == WAIT || state == HOLD) && !accept && !flush
                     && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

    if_id_latch u_if_id_latch (
        .clk        (clk),
        .rst        (rst),
        .load       (latch_load),
        .bubble     (latch_bubble),
        .load_instr (latch_instr_d),
        .load_pc    (pc),
        .instr      (if_id_instr),
        .pc         (if_id_pc),
        .valid      (if_id_valid)
    );

    // Memory must only answer the single request in flight.
    no_stray_response: assert property (
        @(posedge clk) disable iff (rst) imem_valid |-> state == WAIT
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: latency-programmable memory, a request/
// buffer level model checked every cycle, and literal checkpoints.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b1;
    logic        IF_ID_Write = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] branch_target = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int vectors = 0;
    int errors  = 0;
    int lat     = 1;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pc_write      (pc_write),
        .IF_ID_Write   (IF_ID_Write),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory: captures a request mid-cycle, answers lat cycles later for one cycle.
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [15:0] mem_addr = '0;
    initial forever begin
        @(negedge clk);
        if (!rst && imem_req) begin
            mem_busy = 1'b1;
            mem_cnt  = lat;
            mem_addr = imem_addr;
        end
        @(posedge clk);
        #2;
        imem_valid = 1'b0;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(mem_addr);
                mem_busy   = 1'b0;
            end
        end
    end

    // Model: requests in flight (flag = answer must be dropped), a buffered
    // instruction, the PC and the latch contents.
    bit          m_fl[$];
    logic [15:0] m_buf[$];
    logic [15:0] m_pc, m_li, m_lp;
    logic        m_lv;
    int          m_cnt;

    initial forever begin
        logic        acc, resp, live, have, e_req;
        logic [15:0] cur, e_addr;
        @(negedge clk);
        if (rst) begin
            m_fl.delete();
            m_buf.delete();
            m_pc  = 16'h0000;
            m_li  = 16'h0000;
            m_lp  = 16'h0000;
            m_lv  = 1'b0;
            m_cnt = 0;
        end
        acc  = pc_write & IF_ID_Write;
        resp = !rst && imem_valid && m_fl.size() > 0;
        live = resp && !m_fl[0];
        have = live || m_buf.size() > 0;
        cur  = live ? imem_rdata : (m_buf.size() > 0 ? m_buf[0] : 16'h0000);
        e_addr = m_pc;
        if (rst || flush) e_req = 1'b0;
        else if (have && acc) begin
            e_req  = 1'b1;
            e_addr = m_pc + 16'd1;
        end else e_req = (m_fl.size() == 0 && m_buf.size() == 0);

        chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
        if (e_req) chk("imem_addr", {16'd0, imem_addr}, {16'd0, e_addr});
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_lv});
        chk("if_id_instr", {16'd0, if_id_instr}, {16'd0, m_li});
        if (m_lv) chk("if_id_pc", {16'd0, if_id_pc}, {16'd0, m_lp});
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt", {16'd0, stall_cnt}, m_cnt);
`endif

        if (!rst) begin
            if (!flush && !acc && (m_fl.size() > 0 || m_buf.size() > 0) && m_cnt < 16'hFFFF)
                m_cnt++;
            if (resp) void'(m_fl.pop_front());
            if (flush) begin
                foreach (m_fl[i]) m_fl[i] = 1'b1;
                m_buf.delete();
                m_li = 16'h0000;
                m_lv = 1'b0;
                m_pc = branch_target;
            end else if (have && acc) begin
                m_li = cur;
                m_lp = m_pc;
                m_lv = 1'b1;
                m_pc = m_pc + 16'd1;
                if (!live) void'(m_buf.pop_front());
            end else if (live) begin
                m_buf.push_back(cur);
            end else if (!have && IF_ID_Write) begin
                m_li = 16'h0000;
                m_lv = 1'b0;
            end
            if (e_req) m_fl.push_back(1'b0);
        end
    end

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    // {pc_write, IF_ID_Write, flush, branch_target}
    logic [18:0] tbl [16] = '{
        19'h60000, 19'h20000, 19'h40000, 19'h00000,
        19'h60000, 19'h70100, 19'h00000, 19'h60000,
        19'h20000, 19'h10200, 19'h60000, 19'h40000,
        19'h60000, 19'h00000, 19'h7FFFF, 19'h60000
    };

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", {16'd0, if_id_instr}, 32'h0000);
        chk("rst_pc", {16'd0, if_id_pc}, 32'h0000);

        next(); rst = 1'b0;                                   // C0
        for (int k = 0; k < 4; k++) begin
            probe();
            chk("stream_req", {31'd0, imem_req}, 32'd1);
            chk("stream_addr", {16'd0, imem_addr}, k);
            if (k >= 2) begin
                chk("stream_if_pc", {16'd0, if_id_pc}, k - 2);
                chk("stream_if_valid", {31'd0, if_id_valid}, 32'd1);
                chk("stream_if_instr", {16'd0, if_id_instr}, {16'd0, mem_word(16'(k - 2))});
            end
            if (k < 3) next();
        end

        next(); next();                                       // C5
        next(); pc_write = 1'b0; IF_ID_Write = 1'b0;          // C6
        for (int s = 0; s < 3; s++) begin
            probe();
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_if_pc", {16'd0, if_id_pc}, 32'h0004);
            if (s < 2) next();
        end
        next(); pc_write = 1'b1; IF_ID_Write = 1'b1;          // C9
        probe();
        chk("release_addr", {16'd0, imem_addr}, 32'h0006);
        next(); lat = 3;                                      // C10
        probe();
        chk("release_if_pc", {16'd0, if_id_pc}, 32'h0005);
        chk("release_if_instr", {16'd0, if_id_instr}, {16'd0, mem_word(16'h0005)});

        next();                                               // C11
        next(); flush = 1'b1; branch_target = 16'h0040;       // C12
        probe();
        chk("flush_wait_req", {31'd0, imem_req}, 32'd0);
        next(); flush = 1'b0;                                 // C13
        probe();
        chk("flush_wait_bubble", {31'd0, if_id_valid}, 32'd0);
        chk("stale_drop_req", {31'd0, imem_req}, 32'd0);
        next();                                               // C14
        probe();
        chk("redirect_addr", {16'd0, imem_addr}, 32'h0040);
        next(); next();                                       // C16
        next(); lat = 1;                                      // C17
        probe();
        chk("after_redirect_addr", {16'd0, imem_addr}, 32'h0041);

        next(); flush = 1'b1; branch_target = 16'hFFFE;       // C18
        probe();
        chk("flush_resp_req", {31'd0, imem_req}, 32'd0);
        next(); flush = 1'b0;                                 // C19
        probe();
        chk("flush_resp_bubble", {31'd0, if_id_valid}, 32'd0);
        chk("flush_resp_addr", {16'd0, imem_addr}, 32'hFFFE);
        next(); next();                                       // C21
        probe();
        chk("wrap_addr", {16'd0, imem_addr}, 32'h0000);
        chk("wrap_if_pc", {16'd0, if_id_pc}, 32'hFFFE);
        next(); lat = 3;                                      // C22
        probe();
        chk("top_if_pc", {16'd0, if_id_pc}, 32'hFFFF);

        next(); rst = 1'b1; #1;                               // C23
        chk("async_rst_req", {31'd0, imem_req}, 32'd0);
        chk("async_rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("async_rst_instr", {16'd0, if_id_instr}, 32'h0000);
        next(); next(); next();                               // C26
        next(); rst = 1'b0; lat = 2;                          // C27
        probe();
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", {16'd0, imem_addr}, 32'h0000);

        foreach (tbl[i]) begin
            next();
            {pc_write, IF_ID_Write, flush, branch_target} = tbl[i];
        end
        next();
        pc_write = 1'b1; IF_ID_Write = 1'b1; flush = 1'b0;
        repeat (10) next();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
